// File: rtl/filter_peak_detector.sv
// Pulse-height analyser: finds threshold-crossing pulses in the shaped filter stream and emits peak/timestamp/width records.
// Optional pile-up rejection is enabled with `define PEAK_PILEUP_REJECT_EN.
module filter_peak_detector #(
    parameter int SIZE_FILTER_DATA = 15,
    parameter int DATA_W           = SIZE_FILTER_DATA + 1,
    parameter int TS_W             = 32,
    parameter int WIDTH_W          = 8,
    parameter int DEAD_TIME        = 4,
    parameter int MAX_WIDTH        = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic signed [DATA_W-1:0] threshold,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic signed [DATA_W-1:0] evt_amp,
    output logic [TS_W-1:0]          evt_ts,
    output logic [WIDTH_W-1:0]       evt_width,
    output logic [15:0]              lost_cnt,
`ifdef PEAK_PILEUP_REJECT_EN
    output logic [15:0]              pileup_cnt,
`endif
    output logic                     busy
);

    localparam int DEAD_W = (DEAD_TIME < 2) ? 1 : $clog2(DEAD_TIME + 1);
    localparam logic [DEAD_W-1:0]  DEAD_INIT = DEAD_W'(DEAD_TIME);
    localparam logic [WIDTH_W-1:0] WIDTH_MAX = WIDTH_W'(MAX_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
`ifdef PEAK_PILEUP_REJECT_EN
        WAIT_LOW,
`endif
        DEAD
    } state_t;

    state_t                     state, state_next;
    logic [TS_W-1:0]            ts;
    logic signed [DATA_W-1:0]   peak, peak_next;
    logic [TS_W-1:0]            peak_ts, peak_ts_next;
    logic [WIDTH_W-1:0]         width, width_next;
    logic [DEAD_W-1:0]          dead_cnt, dead_next;
    logic                       above;
    logic                       emit;
    logic                       pileup_inc;

    assign above = in_data > threshold;
    assign busy  = (state != IDLE);

    always_comb begin
        state_next   = state;
        peak_next    = peak;
        peak_ts_next = peak_ts;
        width_next   = width;
        dead_next    = dead_cnt;
        emit         = 1'b0;
        pileup_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (above) begin
                    state_next   = TRACK;
                    peak_next    = in_data;
                    peak_ts_next = ts;
                    width_next   = WIDTH_W'(1);
                end
            end
            TRACK: begin
                if (above) begin
                    // Strict compare keeps the first sample of a flat top as the peak.
                    if (in_data > peak) begin
                        peak_next    = in_data;
                        peak_ts_next = ts;
                    end
                    if (width != WIDTH_MAX) begin
                        width_next = width + 1'b1;
                    end
`ifdef PEAK_PILEUP_REJECT_EN
                    else begin
                        state_next = WAIT_LOW;
                        pileup_inc = 1'b1;
                    end
`endif
                end else begin
                    emit       = 1'b1;
                    state_next = (DEAD_TIME == 0) ? IDLE : DEAD;
                    dead_next  = DEAD_INIT;
                end
            end
`ifdef PEAK_PILEUP_REJECT_EN
            WAIT_LOW: begin
                if (!above) begin
                    state_next = (DEAD_TIME == 0) ? IDLE : DEAD;
                    dead_next  = DEAD_INIT;
                end
            end
`endif
            DEAD: begin
                dead_next = dead_cnt - 1'b1;
                if (dead_cnt <= DEAD_W'(1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            ts       <= '0;
            peak     <= '0;
            peak_ts  <= '0;
            width    <= '0;
            dead_cnt <= '0;
        end else begin
            state    <= state_next;
            ts       <= ts + 1'b1;
            peak     <= peak_next;
            peak_ts  <= peak_ts_next;
            width    <= width_next;
            dead_cnt <= dead_next;
        end
    end

    // A record is only lost when the slot is still occupied and not being drained this cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            evt_valid <= 1'b0;
            evt_amp   <= '0;
            evt_ts    <= '0;
            evt_width <= '0;
            lost_cnt  <= '0;
        end else if (emit) begin
            if (!evt_valid || evt_ready) begin
                evt_valid <= 1'b1;
                evt_amp   <= peak;
                evt_ts    <= peak_ts;
                evt_width <= width;
            end else if (lost_cnt != 16'hFFFF) begin
                lost_cnt <= lost_cnt + 1'b1;
            end
        end else if (evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

`ifdef PEAK_PILEUP_REJECT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            pileup_cnt <= '0;
        end else if (pileup_inc && pileup_cnt != 16'hFFFF) begin
            pileup_cnt <= pileup_cnt + 1'b1;
        end
    end
`else
    logic unused_pileup;
    assign unused_pileup = pileup_inc;
`endif

endmodule

// File: tb/tb_filter_peak_detector.sv
// Scoreboard bench for filter_peak_detector: directed pulses push expected records, a negedge monitor checks each handshake.
// Expectations for the pile-up test follow PEAK_PILEUP_REJECT_EN.
module tb_filter_peak_detector;

    localparam int DATA_W = 16;
    localparam int TS_W   = 32;

    typedef struct {
        int          amp;
        logic [31:0] ts;
        int          width;
    } rec_t;

    logic                     clk;
    logic                     reset;
    logic signed [DATA_W-1:0] in_data;
    logic signed [DATA_W-1:0] threshold;
    logic                     evt_valid;
    logic                     evt_ready;
    logic signed [DATA_W-1:0] evt_amp;
    logic [TS_W-1:0]          evt_ts;
    logic [7:0]               evt_width;
    logic [15:0]              lost_cnt;
    logic                     busy;
`ifdef PEAK_PILEUP_REJECT_EN
    logic [15:0]              pileup_cnt;
`endif

    rec_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] model_ts;
    logic [31:0] t, ta, tc, td, te, tf, tg;

    filter_peak_detector #(
        .SIZE_FILTER_DATA(15),
        .DATA_W(DATA_W),
        .TS_W(TS_W),
        .WIDTH_W(8),
        .DEAD_TIME(4),
        .MAX_WIDTH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .threshold(threshold),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_amp(evt_amp),
        .evt_ts(evt_ts),
        .evt_width(evt_width),
        .lost_cnt(lost_cnt),
`ifdef PEAK_PILEUP_REJECT_EN
        .pileup_cnt(pileup_cnt),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference timestamp: the value the timestamp register holds between edges.
    always @(posedge clk) begin
        if (!reset) model_ts <= '0;
        else        model_ts <= model_ts + 1;
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic applyStimulus(input int data, output logic [31:0] ts_of_sample);
        in_data      = DATA_W'(data);
        ts_of_sample = model_ts;
        @(posedge clk);
        #1;
    endtask

    task automatic pushExpected(input int amp, input logic [31:0] ts, input int width);
        rec_t r;
        r.amp   = amp;
        r.ts    = ts;
        r.width = width;
        exp_q.push_back(r);
    endtask

    always @(negedge clk) begin
        if (reset && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL unexpected_event: got amp %0d ts %0d width %0d, expected none",
                         evt_amp, evt_ts, evt_width);
            end else begin
                rec_t r;
                r = exp_q.pop_front();
                checkOutput("evt_amp", evt_amp, r.amp);
                checkOutput("evt_ts", evt_ts, r.ts);
                checkOutput("evt_width", evt_width, r.width);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        evt_ready = 1'b1;
        threshold = 16'sd100;
        in_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", evt_valid, 0);
        checkOutput("reset_amp", evt_amp, 0);
        checkOutput("reset_ts", evt_ts, 0);
        checkOutput("reset_width", evt_width, 0);
        checkOutput("reset_lost", lost_cnt, 0);
        checkOutput("reset_busy", busy, 0);
        reset = 1'b1;

        $display("[TB] basic pulse");
        applyStimulus(0, t);
        applyStimulus(50, t);
        applyStimulus(100, t);
        checkOutput("equal_threshold_busy", busy, 0);
        applyStimulus(120, t);
        checkOutput("start_busy", busy, 1);
        applyStimulus(300, ta);
        applyStimulus(250, t);
        pushExpected(300, ta, 3);
        applyStimulus(90, t);
        checkOutput("emit_valid", evt_valid, 1);
        applyStimulus(0, t);
        checkOutput("valid_one_cycle", evt_valid, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, t);

        $display("[TB] flat top");
        applyStimulus(200, ta);
        applyStimulus(200, t);
        applyStimulus(200, t);
        pushExpected(200, ta, 3);
        applyStimulus(0, t);
        for (int i = 0; i < 6; i++) applyStimulus(0, t);

        $display("[TB] back-pressure drop");
        evt_ready = 1'b0;
        applyStimulus(150, ta);
        pushExpected(150, ta, 1);
        applyStimulus(0, t);
        for (int i = 0; i < 6; i++) applyStimulus(0, t);
        applyStimulus(180, t);
        applyStimulus(0, t);
        checkOutput("drop_lost", lost_cnt, 1);
        checkOutput("held_amp", evt_amp, 150);
        checkOutput("held_ts", evt_ts, ta);
        checkOutput("held_valid", evt_valid, 1);
        evt_ready = 1'b1;
        applyStimulus(0, t);
        checkOutput("drain_valid", evt_valid, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, t);

        $display("[TB] accept and emit together");
        evt_ready = 1'b0;
        applyStimulus(130, tc);
        pushExpected(130, tc, 1);
        applyStimulus(0, t);
        for (int i = 0; i < 6; i++) applyStimulus(0, t);
        applyStimulus(140, td);
        pushExpected(140, td, 1);
        evt_ready = 1'b1;
        applyStimulus(0, t);
        checkOutput("reload_valid", evt_valid, 1);
        checkOutput("reload_amp", evt_amp, 140);
        checkOutput("reload_lost", lost_cnt, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, t);

        $display("[TB] dead time");
        applyStimulus(200, te);
        pushExpected(200, te, 1);
        applyStimulus(0, t);
        applyStimulus(500, t);
        applyStimulus(500, t);
        applyStimulus(500, t);
        checkOutput("dead_busy", busy, 1);
        applyStimulus(500, t);
        checkOutput("dead_end_busy", busy, 0);
        applyStimulus(500, tf);
        checkOutput("after_dead_busy", busy, 1);
        pushExpected(500, tf, 1);
        applyStimulus(0, t);
        for (int i = 0; i < 6; i++) applyStimulus(0, t);

        $display("[TB] reset mid-pulse");
        evt_ready = 1'b0;
        applyStimulus(150, t);
        applyStimulus(0, t);
        checkOutput("pending_valid", evt_valid, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, t);
        applyStimulus(220, t);
        applyStimulus(230, t);
        checkOutput("mid_track_busy", busy, 1);
        reset = 1'b0;
        applyStimulus(240, t);
        checkOutput("rst2_valid", evt_valid, 0);
        checkOutput("rst2_amp", evt_amp, 0);
        checkOutput("rst2_ts", evt_ts, 0);
        checkOutput("rst2_width", evt_width, 0);
        checkOutput("rst2_lost", lost_cnt, 0);
        checkOutput("rst2_busy", busy, 0);
        reset     = 1'b1;
        evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(0, t);
        checkOutput("post_reset_valid", evt_valid, 0);

        $display("[TB] width limit");
        applyStimulus(200, tg);
        for (int i = 0; i < 9; i++) applyStimulus(200, t);
`ifndef PEAK_PILEUP_REJECT_EN
        pushExpected(200, tg, 8);
`endif
        applyStimulus(0, t);
`ifdef PEAK_PILEUP_REJECT_EN
        checkOutput("pileup_cnt", pileup_cnt, 1);
        checkOutput("pileup_no_event", evt_valid, 0);
`else
        checkOutput("sat_valid", evt_valid, 1);
`endif
        for (int i = 0; i < 8; i++) applyStimulus(0, t);

        checkOutput("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
